// File: rtl/preview_queue_pixel_driver_if.sv
// Shared piece types and the pixel/piece bus between the display core and the preview driver.
package preview_queue_pixel_driver_pkg;

  typedef enum logic [2:0] {
    BLANK   = 3'd0,
    PIECE_I = 3'd1,
    PIECE_O = 3'd2,
    PIECE_T = 3'd3,
    PIECE_S = 3'd4,
    PIECE_Z = 3'd5,
    PIECE_J = 3'd6,
    PIECE_L = 3'd7
  } tile_type_t;

  localparam logic [23:0] TILE_BLANK_COLOR = 24'h101010;

  localparam int unsigned TILE_WIDTH  = 16;
  localparam int unsigned TILE_HEIGHT = 16;
  localparam int unsigned HOLD_VSTART = 100;
  localparam int unsigned HOLD_HSTART = 40;

endpackage

interface preview_queue_pixel_driver_if
  import preview_queue_pixel_driver_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 1
);
  logic [9:0]                   VGA_row;
  logic [9:0]                   VGA_col;
  logic                         frame_start;
  logic                         update;
  tile_type_t [NUM_SLOTS-1:0]   piece_types;
  logic                         lockout;
  logic [23:0]                  output_color;
  logic                         active;

  modport master (
    output VGA_row, VGA_col, frame_start, update, piece_types, lockout,
    input  output_color, active
  );

  modport slave (
    input  VGA_row, VGA_col, frame_start, update, piece_types, lockout,
    output output_color, active
  );
endinterface

// File: rtl/preview_queue_pixel_driver.sv
// Preview-window pixel driver: frame-synchronous piece commit, change flash, lockout dim, 2-stage pixel pipe.
module preview_queue_pixel_driver
  import preview_queue_pixel_driver_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = 1,
  parameter int unsigned SLOT_ROWS    = 5,
  parameter int unsigned SLOT_COLS    = 6,
  parameter int unsigned VSTART       = HOLD_VSTART,
  parameter int unsigned HSTART       = HOLD_HSTART,
  parameter int unsigned TILE_W       = TILE_WIDTH,
  parameter int unsigned TILE_H       = TILE_HEIGHT,
  parameter int unsigned SLOT_GAP     = 8,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  preview_queue_pixel_driver_if.slave bus
);

  localparam int unsigned SLOT_H   = SLOT_ROWS * TILE_H;
  localparam int unsigned SLOT_WPX = SLOT_COLS * TILE_W;
  localparam int unsigned PITCH    = SLOT_H + SLOT_GAP;
  localparam int unsigned LAST_ROW = VSTART + (NUM_SLOTS - 1) * PITCH + SLOT_H - 1;
  localparam int unsigned LAST_COL = HSTART + SLOT_WPX - 1;
  localparam int unsigned SLOT_IW  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned ROW_IW   = (SLOT_ROWS > 1) ? $clog2(SLOT_ROWS) : 1;
  localparam int unsigned COL_IW   = (SLOT_COLS > 1) ? $clog2(SLOT_COLS) : 1;

  // Geometry and parameter range checks at elaboration
  if (LAST_ROW > 1023 || LAST_COL > 1023) begin : g_bounds_err
    $error("preview slots extend past pixel 1023");
  end
  if (NUM_SLOTS < 1 || NUM_SLOTS > 6) begin : g_slots_err
    $error("NUM_SLOTS must be 1..6");
  end
  if (FLASH_FRAMES < 1 || FLASH_FRAMES > 15) begin : g_flash_err
    $error("FLASH_FRAMES must be 1..15");
  end

  // Orientation-0 footprint relative to origin (2,2), or (3,2) for I. Tiles off
  // the slot grid can never be queried, so they drop out naturally.
  function automatic logic in_shape(tile_type_t t, logic [ROW_IW-1:0] r, logic [COL_IW-1:0] c);
    int dr;
    int dc;
    dr = int'(r) - ((t == PIECE_I) ? 3 : 2);
    dc = int'(c) - 2;
    case (t)
      PIECE_I: return (dr == 0) && (dc >= -1) && (dc <= 2);
      PIECE_O: return (dr == -1 || dr == 0) && (dc == 0 || dc == 1);
      PIECE_T: return (dr == -1 && dc == 0) || (dr == 0 && dc >= -1 && dc <= 1);
      PIECE_S: return (dr == -1 && (dc == 0 || dc == 1)) || (dr == 0 && (dc == -1 || dc == 0));
      PIECE_Z: return (dr == -1 && (dc == -1 || dc == 0)) || (dr == 0 && (dc == 0 || dc == 1));
      PIECE_J: return (dr == -1 && dc == -1) || (dr == 0 && dc >= -1 && dc <= 1);
      PIECE_L: return (dr == -1 && dc == 1) || (dr == 0 && dc >= -1 && dc <= 1);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [23:0] piece_color(tile_type_t t);
    case (t)
      PIECE_I: return 24'h00F0F0;
      PIECE_O: return 24'hF0F000;
      PIECE_T: return 24'hA000F0;
      PIECE_S: return 24'h00F000;
      PIECE_Z: return 24'hF00000;
      PIECE_J: return 24'h0000F0;
      PIECE_L: return 24'hF0A000;
      default: return TILE_BLANK_COLOR;
    endcase
  endfunction

  function automatic logic [23:0] dim_color(logic [23:0] c);
    return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
  endfunction

  tile_type_t [NUM_SLOTS-1:0]  pending_q, pending_d;
  tile_type_t [NUM_SLOTS-1:0]  displayed_q, displayed_d;
  tile_type_t [NUM_SLOTS-1:0]  commit_src;
  logic                        commit_have;
  logic                        pending_valid_q, pending_valid_d;
  logic                        lockout_disp_q, lockout_disp_d;
  logic [NUM_SLOTS-1:0][3:0]   flash_cnt_q, flash_cnt_d;

  logic [10:0]                 row_w, col_w, row_base;
  logic                        row_hit, col_hit;
  logic                        s1_valid_q, s1_valid_d;
  logic                        in_region_q, in_region_d;
  logic [SLOT_IW-1:0]          slot_q, slot_d;
  logic [ROW_IW-1:0]           trow_q, trow_d;
  logic [COL_IW-1:0]           tcol_q, tcol_d;

  tile_type_t                  sel_type;
  logic                        sel_flash;
  logic                        piece_hit;
  logic [23:0]                 output_color_q, output_color_d;
  logic                        active_q, active_d;

  assign row_w = {1'b0, bus.VGA_row};
  assign col_w = {1'b0, bus.VGA_col};

  // Pending capture and frame-start commit; update+frame_start bypasses straight to display
  always_comb begin
    pending_d       = pending_q;
    displayed_d     = displayed_q;
    pending_valid_d = pending_valid_q;
    lockout_disp_d  = lockout_disp_q;
    flash_cnt_d     = flash_cnt_q;
    commit_src      = bus.update ? bus.piece_types : pending_q;
    commit_have     = bus.update | pending_valid_q;
    if (bus.frame_start) begin
      for (int k = 0; k < int'(NUM_SLOTS); k++) begin
        if (commit_have && (commit_src[k] != displayed_q[k])) begin
          flash_cnt_d[k] = 4'(FLASH_FRAMES);
        end else if (flash_cnt_q[k] != 4'd0) begin
          flash_cnt_d[k] = flash_cnt_q[k] - 4'd1;
        end
      end
      if (commit_have) begin
        displayed_d = commit_src;
      end
      if (bus.update) begin
        pending_d = bus.piece_types;
      end
      pending_valid_d = 1'b0;
      lockout_disp_d  = bus.lockout;
    end else if (bus.update) begin
      pending_d       = bus.piece_types;
      pending_valid_d = 1'b1;
    end
  end

  // Piece/flash/lockout state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NUM_SLOTS); k++) begin
        pending_q[k]   <= BLANK;
        displayed_q[k] <= BLANK;
      end
      pending_valid_q <= 1'b0;
      lockout_disp_q  <= 1'b0;
      flash_cnt_q     <= '0;
    end else begin
      pending_q       <= pending_d;
      displayed_q     <= displayed_d;
      pending_valid_q <= pending_valid_d;
      lockout_disp_q  <= lockout_disp_d;
      flash_cnt_q     <= flash_cnt_d;
    end
  end

  // Stage 1: slot hit and tile row/col by threshold compares at 11 bits
  always_comb begin
    s1_valid_d  = 1'b1;
    row_hit     = 1'b0;
    row_base    = '0;
    slot_d      = '0;
    trow_d      = '0;
    tcol_d      = '0;
    for (int k = 0; k < int'(NUM_SLOTS); k++) begin
      if (row_w >= 11'(VSTART + k * PITCH) && row_w < 11'(VSTART + k * PITCH + SLOT_H)) begin
        row_hit  = 1'b1;
        slot_d   = SLOT_IW'(k);
        row_base = 11'(VSTART + k * PITCH);
      end
    end
    for (int j = 1; j < int'(SLOT_ROWS); j++) begin
      if (row_w >= row_base + 11'(j * TILE_H)) trow_d = ROW_IW'(j);
    end
    col_hit = (col_w >= 11'(HSTART)) && (col_w < 11'(HSTART + SLOT_WPX));
    for (int j = 1; j < int'(SLOT_COLS); j++) begin
      if (col_w >= 11'(HSTART + j * TILE_W)) tcol_d = COL_IW'(j);
    end
    in_region_d = row_hit & col_hit;
  end

  // Stage 1 registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      in_region_q <= 1'b0;
      slot_q      <= '0;
      trow_q      <= '0;
      tcol_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      in_region_q <= in_region_d;
      slot_q      <= slot_d;
      trow_q      <= trow_d;
      tcol_q      <= tcol_d;
    end
  end

  // Stage 2: colour priority outside > blank tile > flash > lockout dim > piece colour
  always_comb begin
    sel_type       = BLANK;
    sel_flash      = 1'b0;
    output_color_d = TILE_BLANK_COLOR;
    active_d       = 1'b0;
    for (int k = 0; k < int'(NUM_SLOTS); k++) begin
      if (slot_q == SLOT_IW'(k)) begin
        sel_type  = displayed_q[k];
        sel_flash = flash_cnt_q[k][0];
      end
    end
    piece_hit = in_shape(sel_type, trow_q, tcol_q);
    if (!s1_valid_q) begin
      output_color_d = '0;
    end else if (in_region_q) begin
      active_d = 1'b1;
      if (piece_hit) begin
        if (sel_flash) begin
          output_color_d = 24'hFFFFFF;
        end else if (lockout_disp_q) begin
          output_color_d = dim_color(piece_color(sel_type));
        end else begin
          output_color_d = piece_color(sel_type);
        end
      end
    end
  end

  // Stage 2 output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      output_color_q <= '0;
      active_q       <= 1'b0;
    end else begin
      output_color_q <= output_color_d;
      active_q       <= active_d;
    end
  end

  assign bus.output_color = output_color_q;
  assign bus.active       = active_q;

endmodule

// File: tb/tb_preview_queue_pixel_driver.sv
// Self-checking bench for preview_queue_pixel_driver: 3 slots, 16px tiles, pitch 88.
module tb_preview_queue_pixel_driver;
  import preview_queue_pixel_driver_pkg::*;

  localparam int NS = 3, VS = 100, HS = 40, TW = 16, TH = 16, GAP = 8, FF = 8, SR = 5, SC = 6;
  localparam int PITCH = SR * TH + GAP;

  logic clk;
  logic rst;
  preview_queue_pixel_driver_if #(.NUM_SLOTS(NS)) bus();

  preview_queue_pixel_driver #(
    .NUM_SLOTS(NS), .SLOT_ROWS(SR), .SLOT_COLS(SC), .VSTART(VS), .HSTART(HS),
    .TILE_W(TW), .TILE_H(TH), .SLOT_GAP(GAP), .FLASH_FRAMES(FF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  tile_type_t  m_disp [NS];
  tile_type_t  m_pend [NS];
  int          m_flash [NS];
  bit          m_pv, m_lk;
  int          p_row, p_col;
  bit          p_rst = 1'b1;
  logic [23:0] exp_color;
  logic        exp_active;
  bit          exp_ok = 1'b0;

  // Absolute tile cells (row*8+col) of each piece in a 5x6 slot
  function automatic bit m_piece(tile_type_t t, int r, int c);
    logic [31:0] cells;
    case (t)
      PIECE_I: cells = {8'd25, 8'd26, 8'd27, 8'd28};
      PIECE_O: cells = {8'd10, 8'd11, 8'd18, 8'd19};
      PIECE_T: cells = {8'd10, 8'd17, 8'd18, 8'd19};
      PIECE_S: cells = {8'd10, 8'd11, 8'd17, 8'd18};
      PIECE_Z: cells = {8'd9,  8'd10, 8'd18, 8'd19};
      PIECE_J: cells = {8'd9,  8'd17, 8'd18, 8'd19};
      PIECE_L: cells = {8'd11, 8'd17, 8'd18, 8'd19};
      default: return 1'b0;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (int'(cells[i*8 +: 8]) == r * 8 + c) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [23:0] m_color(tile_type_t t);
    case (t)
      PIECE_I: return 24'h00F0F0;
      PIECE_O: return 24'hF0F000;
      PIECE_T: return 24'hA000F0;
      PIECE_S: return 24'h00F000;
      PIECE_Z: return 24'hF00000;
      PIECE_J: return 24'h0000F0;
      PIECE_L: return 24'hF0A000;
      default: return TILE_BLANK_COLOR;
    endcase
  endfunction

  task automatic m_pixel(input int row, input int col, output logic [23:0] c, output logic a);
    int base, tr, tc;
    c = TILE_BLANK_COLOR;
    a = 1'b0;
    for (int k = 0; k < NS; k++) begin
      base = VS + k * PITCH;
      if (row >= base && row < base + SR * TH && col >= HS && col < HS + SC * TW) begin
        a  = 1'b1;
        tr = (row - base) / TH;
        tc = (col - HS) / TW;
        if (m_piece(m_disp[k], tr, tc)) begin
          if (m_flash[k] % 2 == 1) c = 24'hFFFFFF;
          else if (m_lk)           c = (m_color(m_disp[k]) >> 1) & 24'h7F7F7F;
          else                     c = m_color(m_disp[k]);
        end
      end
    end
  endtask

  // Model: expected output at this edge, then advance piece state
  always @(posedge clk) begin
    tile_type_t src [NS];
    bit have;
    if (rst || p_rst) begin
      exp_color  = 24'h0;
      exp_active = 1'b0;
    end else begin
      m_pixel(p_row, p_col, exp_color, exp_active);
    end
    if (rst) begin
      for (int k = 0; k < NS; k++) begin
        m_disp[k] = BLANK; m_pend[k] = BLANK; m_flash[k] = 0;
      end
      m_pv = 1'b0;
      m_lk = 1'b0;
    end else if (bus.frame_start) begin
      have = bus.update || m_pv;
      for (int k = 0; k < NS; k++) src[k] = bus.update ? bus.piece_types[k] : m_pend[k];
      for (int k = 0; k < NS; k++) begin
        if (have && src[k] != m_disp[k]) m_flash[k] = FF;
        else if (m_flash[k] > 0)         m_flash[k] = m_flash[k] - 1;
        if (have) m_disp[k] = src[k];
        if (bus.update) m_pend[k] = bus.piece_types[k];
      end
      m_pv = 1'b0;
      m_lk = bus.lockout;
    end else if (bus.update) begin
      for (int k = 0; k < NS; k++) m_pend[k] = bus.piece_types[k];
      m_pv = 1'b1;
    end
    p_row  = int'(bus.VGA_row);
    p_col  = int'(bus.VGA_col);
    p_rst  = rst;
    exp_ok = 1'b1;
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (exp_ok) begin
      checks++;
      if (bus.output_color !== exp_color || bus.active !== exp_active) begin
        errors++;
        $display("FAIL pixel_model t=%0t got color=%h active=%b expected color=%h active=%b",
                 $time, bus.output_color, bus.active, exp_color, exp_active);
      end
    end
  end

  // Hand-computed expectation, checked on both the DUT and the model
  task automatic lit(input string name, input logic [23:0] c, input logic a);
    checks++;
    if (bus.output_color !== c || bus.active !== a) begin
      errors++;
      $display("FAIL %s got color=%h active=%b expected color=%h active=%b",
               name, bus.output_color, bus.active, c, a);
    end
    checks++;
    if (exp_color !== c || exp_active !== a) begin
      errors++;
      $display("FAIL %s_model got color=%h active=%b expected color=%h active=%b",
               name, exp_color, exp_active, c, a);
    end
  endtask

  task automatic probe(input int r, input int c);
    bus.VGA_row = 10'(r);
    bus.VGA_col = 10'(c);
    repeat (2) @(negedge clk);
  endtask

  task automatic set_types(input tile_type_t a, input tile_type_t b, input tile_type_t c);
    bus.piece_types[0] = a;
    bus.piece_types[1] = b;
    bus.piece_types[2] = c;
  endtask

  task automatic do_update(input tile_type_t a, input tile_type_t b, input tile_type_t c);
    set_types(a, b, c);
    bus.update = 1'b1;
    @(negedge clk);
    bus.update = 1'b0;
  endtask

  task automatic frame();
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.VGA_row = '0; bus.VGA_col = '0;
    bus.frame_start = 1'b0; bus.update = 1'b0; bus.lockout = 1'b0;
    set_types(BLANK, BLANK, BLANK);
    repeat (3) @(negedge clk);
    lit("reset_state", 24'h000000, 1'b0);
    rst = 1'b0;

    probe(100, 40);  lit("blank_tile", TILE_BLANK_COLOR, 1'b1);
    probe(180, 40);  lit("gap_row", TILE_BLANK_COLOR, 1'b0);

    do_update(PIECE_T, PIECE_I, PIECE_O);
    probe(132, 72);  lit("pre_commit_blank", TILE_BLANK_COLOR, 1'b1);
    frame();
    probe(132, 72);  lit("t_cnt8", 24'hA000F0, 1'b1);
    frame();
    probe(132, 72);  lit("t_cnt7_white", 24'hFFFFFF, 1'b1);
    repeat (7) frame();
    probe(132, 72);  lit("t_settled", 24'hA000F0, 1'b1);
    probe(236, 72);  lit("i_slot1", 24'h00F0F0, 1'b1);

    do_update(PIECE_T, PIECE_I, PIECE_O);
    do_update(PIECE_S, PIECE_I, PIECE_O);
    frame();
    probe(132, 72);  lit("s_cnt8", 24'h00F000, 1'b1);
    frame();
    probe(132, 72);  lit("s_cnt7_white", 24'hFFFFFF, 1'b1);
    probe(236, 72);  lit("i_no_flash", 24'h00F0F0, 1'b1);
    repeat (7) frame();
    probe(132, 72);  lit("s_settled", 24'h00F000, 1'b1);

    do_update(PIECE_T, PIECE_I, PIECE_O);
    repeat (9) frame();
    probe(132, 72);  lit("t_again", 24'hA000F0, 1'b1);
    bus.lockout = 1'b1;
    probe(132, 72);  lit("lockout_mid_frame", 24'hA000F0, 1'b1);
    frame();
    probe(132, 72);  lit("t_dim", 24'h500078, 1'b1);

    bus.lockout = 1'b0;
    set_types(PIECE_Z, PIECE_Z, PIECE_Z);
    bus.update = 1'b1; bus.frame_start = 1'b1;
    @(negedge clk);
    bus.update = 1'b0; bus.frame_start = 1'b0;
    probe(132, 72);  lit("z_bypass_slot0", 24'hF00000, 1'b1);
    probe(308, 72);  lit("z_bypass_slot2", 24'hF00000, 1'b1);
    frame();
    probe(132, 72);  lit("z_cnt7_white", 24'hFFFFFF, 1'b1);

    rst = 1'b1;
    @(negedge clk);
    lit("rst_mid_flash", 24'h000000, 1'b0);
    rst = 1'b0;
    frame();
    probe(132, 72);  lit("post_rst_blank", TILE_BLANK_COLOR, 1'b1);

    // Randomised traffic checked every cycle by the model
    for (int n = 0; n < 4000; n++) begin
      rst             = ($urandom_range(0, 599) == 0);
      bus.update      = ($urandom_range(0, 15) == 0);
      bus.frame_start = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 49) == 0) bus.lockout = ~bus.lockout;
      for (int k = 0; k < NS; k++) bus.piece_types[k] = tile_type_t'(3'($urandom_range(0, 7)));
      bus.VGA_row = 10'($urandom_range(90, 370));
      bus.VGA_col = 10'($urandom_range(30, 150));
      @(negedge clk);
    end
    rst = 1'b0; bus.update = 1'b0; bus.frame_start = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
